// File: rtl/execute_mc.sv
// Execute stage: ALU plus optional iterative shift-add multiplier, registered into EX/MEM.
// Latency: ALU ops 1 cycle back-to-back; multiply N+2 cycles from first presentation.
// Backpressure: stall_E holds upstream while a multiply runs; flush_E aborts, reset dominates.
module execute_mc #(
  parameter int N      = 64,
  parameter int MUL_EN = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic         flush_E,
  input  logic         AluSrc,
  input  logic [3:0]   AluControl,
  input  logic         MulOp,
  input  logic [N-1:0] PC_E,
  input  logic [N-1:0] signImm_E,
  input  logic [N-1:0] readData1_E,
  input  logic [N-1:0] readData2_E,
  output logic         stall_E,
  output logic [N-1:0] PCBranch_M,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] writeData_M,
  output logic         zero_M,
  output logic         valid_M
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  prod_q, prod_d;

  logic          mul_on;
  logic          mul_req;
  logic          accept;
  logic [N-1:0]  alu_b;
  logic [N-1:0]  alu_res;
  logic [N-1:0]  result;

  assign mul_on  = (MUL_EN != 0);
  assign mul_req = mul_on & valid_E & MulOp & ~flush_E;
  assign stall_E = mul_req & (state_q != DONE);
  assign accept  = valid_E & ~stall_E & ~flush_E;

  // ALU datapath and selection of the value written to aluResult_M
  always_comb begin
    alu_b   = AluSrc ? signImm_E : readData2_E;
    alu_res = '0;
    case (AluControl)
      4'b0000: alu_res = readData1_E & alu_b;
      4'b0001: alu_res = readData1_E | alu_b;
      4'b0010: alu_res = readData1_E + alu_b;
      4'b0110: alu_res = readData1_E - alu_b;
      4'b0111: alu_res = alu_b;
      4'b1100: alu_res = ~(readData1_E | alu_b);
      default: alu_res = '0;
    endcase
    // Only reachable with the multiplier present; DONE means the product is ready
    result = (mul_on && state_q == DONE) ? prod_q : alu_res;
  end

  // Multiplier next-state: operands latched on entry so held inputs cannot disturb the product
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (mul_req) begin
          state_d = BUSY;
          a_d     = readData1_E;
          b_d     = readData2_E;
          prod_d  = '0;
          count_d = '0;
        end
      end
      BUSY: begin
        if (b_q[count_q]) begin
          prod_d = prod_q + (a_q << count_q);
        end
        count_d = count_q + 1'b1;
        if (count_q == LAST_BIT) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_E) begin
      state_d = IDLE;
    end
  end

  // Multiplier state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
    end
  end

  // EX/MEM pipeline register: data loads only on accept, valid pulses per accept
  always_ff @(posedge clk) begin
    if (reset) begin
      aluResult_M <= '0;
      zero_M      <= 1'b0;
      PCBranch_M  <= '0;
      writeData_M <= '0;
      valid_M     <= 1'b0;
    end else begin
      valid_M <= accept;
      if (accept) begin
        aluResult_M <= result;
        zero_M      <= (result == '0);
        PCBranch_M  <= PC_E + (signImm_E << 2);
        writeData_M <= readData2_E;
      end
    end
  end

endmodule

// File: tb/tb_execute_mc.sv
// Bench for execute_mc (N=64, MUL_EN=1): directed vectors, multi-cycle sequences, random run.
// Every cycle is checked against a transaction-level reference model.
// Upstream inputs are held whenever the model expects a stall.
module tb_execute_mc;
  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset, valid_E, flush_E, AluSrc, MulOp;
  logic [3:0]   AluControl;
  logic [N-1:0] PC_E, signImm_E, readData1_E, readData2_E;
  logic         stall_E, zero_M, valid_M;
  logic [N-1:0] PCBranch_M, aluResult_M, writeData_M;

  execute_mc #(.N(N), .MUL_EN(1)) dut (
    .clk(clk), .reset(reset), .valid_E(valid_E), .flush_E(flush_E),
    .AluSrc(AluSrc), .AluControl(AluControl), .MulOp(MulOp),
    .PC_E(PC_E), .signImm_E(signImm_E), .readData1_E(readData1_E), .readData2_E(readData2_E),
    .stall_E(stall_E), .PCBranch_M(PCBranch_M), .aluResult_M(aluResult_M),
    .writeData_M(writeData_M), .zero_M(zero_M), .valid_M(valid_M)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: multiply tracked as "edges since first presentation"
  logic [N-1:0] m_res, m_pcb, m_wd, ma, mb;
  logic         m_zero, m_vld, in_mul, m_acc, m_flush, last_stall;
  int           cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] ref_alu(input logic [3:0] c, input logic [N-1:0] a, input logic [N-1:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return b;
      4'b1100: return ~(a | b);
      default: return '0;
    endcase
  endfunction

  task automatic m_load(input logic [N-1:0] r);
    m_res  = r;
    m_zero = (r == '0);
    m_pcb  = PC_E + signImm_E * 4;
    m_wd   = readData2_E;
    m_vld  = 1'b1;
    m_acc  = 1'b1;
  endtask

  task automatic model_edge();
    m_acc   = 1'b0;
    m_flush = 1'b0;
    if (reset) begin
      m_res = '0; m_pcb = '0; m_wd = '0; m_zero = 1'b0; m_vld = 1'b0;
      in_mul = 1'b0; cnt = 0;
    end else if (flush_E) begin
      m_vld = 1'b0; in_mul = 1'b0; m_flush = 1'b1;
    end else if (valid_E && MulOp) begin
      if (!in_mul) begin
        in_mul = 1'b1; cnt = 1; ma = readData1_E; mb = readData2_E; m_vld = 1'b0;
      end else if (cnt < N + 1) begin
        cnt++; m_vld = 1'b0;
      end else begin
        m_load(ma * mb);
        in_mul = 1'b0;
      end
    end else if (valid_E) begin
      m_load(ref_alu(AluControl, readData1_E, AluSrc ? signImm_E : readData2_E));
    end else begin
      m_vld = 1'b0;
    end
  endtask

  // One clock: check stall before the edge, advance model, check registered outputs after it
  task automatic cycle();
    logic exp_stall;
    #1;
    exp_stall = valid_E && MulOp && !flush_E && !(in_mul && cnt == N + 1);
    last_stall = stall_E;
    chk("stall_E", 64'(stall_E), 64'(exp_stall));
    model_edge();
    @(posedge clk);
    #1;
    chk("valid_M", 64'(valid_M), 64'(m_vld));
    chk("aluResult_M", aluResult_M, m_res);
    chk("zero_M", 64'(zero_M), 64'(m_zero));
    chk("PCBranch_M", PCBranch_M, m_pcb);
    chk("writeData_M", writeData_M, m_wd);
  endtask

  task automatic set_in(input logic v, input logic f, input logic src, input logic [3:0] code,
                        input logic mul, input logic [N-1:0] pc, input logic [N-1:0] imm,
                        input logic [N-1:0] a, input logic [N-1:0] b);
    valid_E = v; flush_E = f; AluSrc = src; AluControl = code; MulOp = mul;
    PC_E = pc; signImm_E = imm; readData1_E = a; readData2_E = b;
  endtask

  task automatic run_mul(input logic [N-1:0] a, input logic [N-1:0] b, output int stalls, output int got);
    set_in(1, 0, 0, 4'b0010, 1, 64'h200, 64'h3, a, b);
    stalls = 0;
    got    = 0;
    for (int i = 1; i <= 100; i++) begin
      cycle();
      if (last_stall) stalls++;
      if (valid_M) begin
        got = i;
        break;
      end
    end
  endtask

  function automatic logic [N-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  typedef struct {
    logic         src;
    logic [3:0]   code;
    logic [N-1:0] pc, imm, a, b;
    logic [N-1:0] exp_res;
    logic         exp_zero;
    logic [N-1:0] exp_pcb;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls, got, errs;
    logic pat[$];
    logic exp_pat[$];

    vecs[0] = '{0, 4'b0010, 64'h40, 64'h1, 64'd5, 64'd7, 64'd12, 0, 64'h44};
    vecs[1] = '{0, 4'b0110, 64'h40, 64'h1, 64'd9, 64'd9, 64'd0, 1, 64'h44};
    vecs[2] = '{1, 4'b0111, 64'h100, 64'hFFFF_FFFF_FFFF_FFFC, 64'd1, 64'd2,
                64'hFFFF_FFFF_FFFF_FFFC, 0, 64'hF0};
    vecs[3] = '{0, 4'b0010, 64'h40, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1, 64'h44};
    vecs[4] = '{0, 4'b0000, 64'h40, 64'h1, 64'hF0F0, 64'hFF00, 64'hF000, 0, 64'h44};
    vecs[5] = '{0, 4'b0001, 64'h40, 64'h1, 64'hF0F0, 64'h0F0F, 64'hFFFF, 0, 64'h44};
    vecs[6] = '{0, 4'b1100, 64'h40, 64'h1, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h44};
    vecs[7] = '{0, 4'b0011, 64'h40, 64'h1, 64'd3, 64'd4, 64'd0, 1, 64'h44};
    vecs[8] = '{0, 4'b0110, 64'h40, 64'h1, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 0, 64'h44};
    vecs[9] = '{0, 4'b1111, 64'h40, 64'h1, 64'd6, 64'd6, 64'd0, 1, 64'h44};

    m_res = '0; m_pcb = '0; m_wd = '0; m_zero = 0; m_vld = 0; in_mul = 0; cnt = 0;
    ma = '0; mb = '0; m_acc = 0; m_flush = 0; last_stall = 0;

    // Reset state
    reset = 1;
    set_in(0, 0, 0, 4'b0000, 0, 64'h0, 64'h0, 64'h0, 64'h0);
    cycle();
    cycle();
    chk("reset_valid_M", 64'(valid_M), 64'd0);
    chk("reset_aluResult_M", aluResult_M, 64'd0);
    reset = 0;

    // Directed ALU / branch vectors, back-to-back
    for (int i = 0; i < 10; i++) begin
      set_in(1, 0, vecs[i].src, vecs[i].code, 0, vecs[i].pc, vecs[i].imm, vecs[i].a, vecs[i].b);
      cycle();
      chk($sformatf("vec%0d_res", i), aluResult_M, vecs[i].exp_res);
      chk($sformatf("vec%0d_zero", i), 64'(zero_M), 64'(vecs[i].exp_zero));
      chk($sformatf("vec%0d_pcb", i), PCBranch_M, vecs[i].exp_pcb);
      chk($sformatf("vec%0d_vld", i), 64'(valid_M), 64'd1);
    end

    // Multiply 123456 * 1000
    run_mul(64'd123456, 64'd1000, stalls, got);
    chk("mul_stall_cycles", 64'(stalls), 64'd65);
    chk("mul_valid_cycle", 64'(got), 64'd66);
    chk("mul_result", aluResult_M, 64'd123456000);

    // Multiply by zero
    run_mul(64'd987, 64'd0, stalls, got);
    chk("mul0_valid_cycle", 64'(got), 64'd66);
    chk("mul0_result", aluResult_M, 64'd0);
    chk("mul0_zero", 64'(zero_M), 64'd1);

    // Flush after count reaches 10, then a 1-cycle ADD
    set_in(1, 0, 0, 4'b0010, 1, 64'h300, 64'h1, 64'd77, 64'd55);
    for (int i = 0; i < 11; i++) cycle();
    flush_E = 1;
    cycle();
    chk("flush_stall", 64'(last_stall), 64'd0);
    chk("flush_valid_M", 64'(valid_M), 64'd0);
    set_in(1, 0, 0, 4'b0010, 0, 64'h300, 64'h1, 64'd2, 64'd3);
    cycle();
    chk("post_flush_add_vld", 64'(valid_M), 64'd1);
    chk("post_flush_add_res", aluResult_M, 64'd5);

    // Reset during BUSY, then ADD 2+2
    set_in(1, 0, 0, 4'b0010, 1, 64'h300, 64'h1, 64'd11, 64'd13);
    for (int i = 0; i < 20; i++) cycle();
    reset = 1;
    valid_E = 0;
    cycle();
    cycle();
    chk("rst_busy_vld", 64'(valid_M), 64'd0);
    chk("rst_busy_res", aluResult_M, 64'd0);
    chk("rst_busy_pcb", PCBranch_M, 64'd0);
    reset = 0;
    set_in(1, 0, 0, 4'b0010, 0, 64'h0, 64'h0, 64'd2, 64'd2);
    cycle();
    chk("rst_add_stall", 64'(last_stall), 64'd0);
    chk("rst_add_vld", 64'(valid_M), 64'd1);
    chk("rst_add_res", aluResult_M, 64'd4);

    // Back-to-back ADD, MUL, ADD
    set_in(1, 0, 0, 4'b0010, 0, 64'h0, 64'h0, 64'd1, 64'd1);
    cycle();
    pat.push_back(valid_M);
    set_in(1, 0, 0, 4'b0010, 1, 64'h0, 64'h0, 64'd6, 64'd7);
    for (int i = 0; i < 100; i++) begin
      cycle();
      pat.push_back(valid_M);
      if (m_acc) break;
    end
    chk("b2b_mul_res", aluResult_M, 64'd42);
    set_in(1, 0, 0, 4'b0010, 0, 64'h0, 64'h0, 64'd8, 64'd8);
    cycle();
    pat.push_back(valid_M);
    chk("b2b_add_res", aluResult_M, 64'd16);
    exp_pat.push_back(1'b1);
    for (int i = 0; i < 65; i++) exp_pat.push_back(1'b0);
    exp_pat.push_back(1'b1);
    exp_pat.push_back(1'b1);
    chk("b2b_len", 64'(pat.size()), 64'(exp_pat.size()));
    errs = 0;
    for (int i = 0; i < pat.size() && i < exp_pat.size(); i++) if (pat[i] !== exp_pat[i]) errs++;
    chk("b2b_pattern_errs", 64'(errs), 64'd0);

    // Random run with flushes and operand churn during multiplies
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        set_in(0, $urandom_range(0, 7) == 0, $urandom_range(0, 1), 4'($urandom_range(0, 15)),
               $urandom_range(0, 1), rnd64(), rnd64(), rnd64(), rnd64());
        cycle();
        continue;
      end
      set_in(1, 0, $urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom_range(0, 4) == 0,
             rnd64(), rnd64(), rnd64(), rnd64());
      if ($urandom_range(0, 3) == 0) readData2_E = readData1_E;
      if ($urandom_range(0, 3) == 0) readData1_E = 64'($urandom_range(0, 1000));
      for (int g = 0; g < 80; g++) begin
        flush_E = ($urandom_range(0, 39) == 0);
        cycle();
        if (m_acc || m_flush) break;
        if (in_mul && $urandom_range(0, 3) == 0) begin
          readData1_E = rnd64();
          readData2_E = rnd64();
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
